// File: rtl/wb_pkg.sv
// Purpose: shared types and default widths for the multi-source writeback stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_REG_ADDR_W = 5;

    // Encoding of the in-order pipe result select.
    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_PC4  = 2'd2,
        RES_IMM  = 2'd3
    } result_src_e;

    // One buffered long-latency completion.
    typedef struct packed {
        logic [DEF_REG_ADDR_W-1:0] rd;
        logic [DEF_XLEN-1:0]       data;
    } lu_entry_t;

endpackage

// File: rtl/wb_lu_fifo.sv
// Purpose: small generic FIFO buffering one long-latency completion channel.
// Latency: an entry becomes visible at head the cycle after it is pushed (no bypass).
// Backpressure: full is derived from the registered count only; pushes while full are ignored.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset (empties the FIFO)
//   push, pushData write strobe and entry
//   pop            read strobe (ignored while empty)
//   full, empty    occupancy flags from registered state
//   head           oldest entry (undefined while empty)
module wb_lu_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = lu_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t pushData,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign head   = mem[rdPtr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/wb_stage_mc.sv
// Purpose: merges the in-order pipe result with NUM_LU buffered long-latency completions onto one RF write port.
// Latency: one cycle from winning arbitration to RegWriteW/RdW/ResultW.
// Backpressure: lu_ready per channel from its FIFO's registered fullness; StallReq asks the hazard unit for a bubble when a buffered entry starves.
//
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   ValidM, RegWriteM, ResultSrcM, RdM, ALUResultM, LoadDataM, PCPlus4M, ImmExtM
//                                     in-order pipe result and its candidates
//   lu_valid, lu_ready, lu_rd, lu_data per-channel completion handshake; packed, channel 0 in the LSBs
//   RegWriteW, RdW, ResultW           registered register-file write
//   StallReq                          starvation bubble request
//   lu_busy                           any channel FIFO holds an entry
//   stat_pipe_wr, stat_lu_wr, stat_stall_cyc
//                                     wrapping event counters, present only with WB_STATS_EN defined
module wb_stage_mc
    import wb_pkg::*;
#(
    parameter int XLEN         = DEF_XLEN,
    parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int NUM_LU       = 2,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ValidM,
    input  logic                       RegWriteM,
    input  logic [1:0]                 ResultSrcM,
    input  logic [REG_ADDR_W-1:0]      RdM,
    input  logic [XLEN-1:0]            ALUResultM,
    input  logic [XLEN-1:0]            LoadDataM,
    input  logic [XLEN-1:0]            PCPlus4M,
    input  logic [XLEN-1:0]            ImmExtM,
    input  logic [NUM_LU-1:0]          lu_valid,
    output logic [NUM_LU-1:0]          lu_ready,
    input  logic [NUM_LU*REG_ADDR_W-1:0] lu_rd,
    input  logic [NUM_LU*XLEN-1:0]     lu_data,
    output logic                       RegWriteW,
    output logic [REG_ADDR_W-1:0]      RdW,
    output logic [XLEN-1:0]            ResultW,
    output logic                       StallReq,
    output logic                       lu_busy
`ifdef WB_STATS_EN
    ,
    output logic [31:0]                stat_pipe_wr,
    output logic [31:0]                stat_lu_wr,
    output logic [31:0]                stat_stall_cyc
`endif
);

    localparam int PTR_W = (NUM_LU > 1) ? $clog2(NUM_LU) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } luEntry_t;

    luEntry_t          headEntry [NUM_LU];
    luEntry_t          grantEntry;
    logic [NUM_LU-1:0] fifoFull;
    logic [NUM_LU-1:0] fifoEmpty;
    logic [NUM_LU-1:0] fifoPush;
    logic [NUM_LU-1:0] fifoPop;

    logic              pipeCand;
    logic [XLEN-1:0]   pipeResult;

    logic [PTR_W-1:0]  rrPtr;
    logic [PTR_W-1:0]  rrPtrNext;
    logic              hiFound;
    logic              loFound;
    logic [PTR_W-1:0]  hiIdx;
    logic [PTR_W-1:0]  loIdx;
    logic              luFound;
    logic [PTR_W-1:0]  luIdx;
    logic              luGrant;

    logic [STV_W-1:0]  starveCnt;
    logic [STV_W-1:0]  starveNext;

    // ------------------------------------------------------------------
    // Channel FIFOs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_LU; g++) begin : gLu
        luEntry_t inEntry;

        assign inEntry     = {lu_rd[g*REG_ADDR_W +: REG_ADDR_W], lu_data[g*XLEN +: XLEN]};
        assign lu_ready[g] = ~fifoFull[g];
        // x0 completions are accepted on the handshake but dropped.
        assign fifoPush[g] = lu_valid[g] & ~fifoFull[g] & (inEntry.rd != '0);

        wb_lu_fifo #(
            .DEPTH   (BUF_DEPTH),
            .entry_t (luEntry_t)
        ) uFifo (
            .clk      (clk),
            .reset    (reset),
            .push     (fifoPush[g]),
            .pushData (inEntry),
            .pop      (fifoPop[g]),
            .full     (fifoFull[g]),
            .empty    (fifoEmpty[g]),
            .head     (headEntry[g])
        );
    end

    assign lu_busy = ~&fifoEmpty;

    // ------------------------------------------------------------------
    // Pipe candidate
    // ------------------------------------------------------------------
    assign pipeCand = ValidM & RegWriteM & (RdM != '0);

    always_comb begin
        pipeResult = ALUResultM;
        case (result_src_e'(ResultSrcM))
            RES_ALU:  pipeResult = ALUResultM;
            RES_LOAD: pipeResult = LoadDataM;
            RES_PC4:  pipeResult = PCPlus4M;
            RES_IMM:  pipeResult = ImmExtM;
            default:  pipeResult = ALUResultM;
        endcase
    end

    // ------------------------------------------------------------------
    // Round-robin search. Scanning downward leaves the lowest non-empty
    // index at or above the pointer in hiIdx and the lowest overall in
    // loIdx; the latter is the wrap-around choice.
    // ------------------------------------------------------------------
    always_comb begin
        hiFound = 1'b0;
        hiIdx   = '0;
        loFound = 1'b0;
        loIdx   = '0;
        for (int i = NUM_LU - 1; i >= 0; i--) begin
            if (!fifoEmpty[i]) begin
                if (PTR_W'(i) >= rrPtr) begin
                    hiFound = 1'b1;
                    hiIdx   = PTR_W'(i);
                end
                loFound = 1'b1;
                loIdx   = PTR_W'(i);
            end
        end
        luFound = hiFound | loFound;
        luIdx   = hiFound ? hiIdx : loIdx;
    end

    // The pipe has no buffering, so it always wins.
    assign luGrant    = ~pipeCand & luFound;
    assign grantEntry = headEntry[luIdx];

    always_comb begin
        fifoPop = '0;
        for (int i = 0; i < NUM_LU; i++) begin
            fifoPop[i] = luGrant && (luIdx == PTR_W'(i));
        end
    end

    always_comb begin
        rrPtrNext = rrPtr;
        if (luGrant) begin
            rrPtrNext = (luIdx == PTR_W'(NUM_LU - 1)) ? '0 : luIdx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rrPtr <= '0;
        else       rrPtr <= rrPtrNext;
    end

    // ------------------------------------------------------------------
    // Registered write port. ResultW holds on idle cycles so the data
    // lines do not toggle without a write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW <= 1'b0;
            RdW       <= '0;
            ResultW   <= '0;
        end else if (pipeCand) begin
            RegWriteW <= 1'b1;
            RdW       <= RdM;
            ResultW   <= pipeResult;
        end else if (luGrant) begin
            RegWriteW <= 1'b1;
            RdW       <= grantEntry.rd;
            ResultW   <= grantEntry.data;
        end else begin
            RegWriteW <= 1'b0;
            RdW       <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation guard. StallReq mirrors the saturated counter, so it
    // drops at the same edge that retires the popped entry.
    // ------------------------------------------------------------------
    always_comb begin
        starveNext = starveCnt;
        if (luGrant || !lu_busy) begin
            starveNext = '0;
        end else if (starveCnt != STV_W'(STARVE_LIMIT)) begin
            starveNext = starveCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starveCnt <= '0;
            StallReq  <= 1'b0;
        end else begin
            starveCnt <= starveNext;
            StallReq  <= (starveNext == STV_W'(STARVE_LIMIT));
        end
    end

`ifdef WB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_pipe_wr   <= '0;
            stat_lu_wr     <= '0;
            stat_stall_cyc <= '0;
        end else begin
            if (pipeCand) stat_pipe_wr   <= stat_pipe_wr + 32'd1;
            if (luGrant)  stat_lu_wr     <= stat_lu_wr + 32'd1;
            if (StallReq) stat_stall_cyc <= stat_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_mc.sv
// Purpose: directed scoreboard bench for wb_stage_mc (NUM_LU=2, BUF_DEPTH=2, STARVE_LIMIT=8).
// Latency: expected writes are queued when issued; a negedge monitor pops and compares each RF write.
// Backpressure: lu_ready, StallReq and lu_busy are checked at fixed points in the directed sequence.
module tb_wb_stage_mc;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM;
    logic [31:0] LoadDataM;
    logic [31:0] PCPlus4M;
    logic [31:0] ImmExtM;
    logic [1:0]  lu_valid;
    logic [1:0]  lu_ready;
    logic [9:0]  lu_rd;
    logic [63:0] lu_data;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        StallReq;
    logic        lu_busy;
`ifdef WB_STATS_EN
    logic [31:0] stat_pipe_wr;
    logic [31:0] stat_lu_wr;
    logic [31:0] stat_stall_cyc;
`endif

    wb_stage_mc #(
        .XLEN         (32),
        .REG_ADDR_W   (5),
        .NUM_LU       (2),
        .BUF_DEPTH    (2),
        .STARVE_LIMIT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ValidM     (ValidM),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .LoadDataM  (LoadDataM),
        .PCPlus4M   (PCPlus4M),
        .ImmExtM    (ImmExtM),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .ResultW    (ResultW),
        .StallReq   (StallReq),
        .lu_busy    (lu_busy)
`ifdef WB_STATS_EN
        ,
        .stat_pipe_wr   (stat_pipe_wr),
        .stat_lu_wr     (stat_lu_wr),
        .stat_stall_cyc (stat_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t       expQ [$];
    exp_t       monE;
    int         checks = 0;
    int         fails  = 0;
    logic [1:0] readyExp [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ValidM    = 1'b0;
        RegWriteM = 1'b0;
        lu_valid  = '0;
    endtask

    // Drive a pipe result; the unselected candidates carry distinct junk.
    task automatic pipeWr(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] val,
                          input logic expectWr);
        ValidM     = 1'b1;
        RegWriteM  = 1'b1;
        RdM        = rd;
        ResultSrcM = src;
        ALUResultM = val ^ 32'h0101_0101;
        LoadDataM  = val ^ 32'h0202_0202;
        PCPlus4M   = val ^ 32'h0404_0404;
        ImmExtM    = val ^ 32'h0808_0808;
        case (src)
            2'd0:    ALUResultM = val;
            2'd1:    LoadDataM  = val;
            2'd2:    PCPlus4M   = val;
            default: ImmExtM    = val;
        endcase
        if (expectWr) expQ.push_back(exp_t'({rd, val}));
    endtask

    task automatic luDrive(input int ch, input logic [4:0] rd, input logic [31:0] d);
        lu_valid[ch]        = 1'b1;
        lu_rd[ch*5 +: 5]    = rd;
        lu_data[ch*32 +: 32] = d;
    endtask

    task automatic expLu(input logic [4:0] rd, input logic [31:0] d);
        expQ.push_back(exp_t'({rd, d}));
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_regwrite"}, 32'(RegWriteW), 32'd0);
        check({tag, "_rd"},       32'(RdW),       32'd0);
        check({tag, "_result"},   ResultW,        32'd0);
        check({tag, "_stall"},    32'(StallReq),  32'd0);
        check({tag, "_busy"},     32'(lu_busy),   32'd0);
        check({tag, "_ready"},    32'(lu_ready),  32'h3);
    endtask

    // Scoreboard monitor: every RF write must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && RegWriteW) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: actual rd=%0d data=0x%0h required=no write", RdW, ResultW);
            end else begin
                monE = expQ.pop_front();
                check("wb_rd",   32'(RdW), 32'(monE.rd));
                check("wb_data", ResultW,  monE.data);
            end
        end
    end

    initial begin
        readyExp[0] = 2'b01;
        readyExp[1] = 2'b11;
        readyExp[2] = 2'b11;
        readyExp[3] = 2'b11;

        reset      = 1'b1;
        idle();
        ResultSrcM = '0;
        RdM        = '0;
        ALUResultM = '0;
        LoadDataM  = '0;
        PCPlus4M   = '0;
        ImmExtM    = '0;
        lu_rd      = '0;
        lu_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        reset = 1'b0;

        // Pipe writes through each result source.
        pipeWr(5'd5, 2'd3, 32'h1234, 1'b1);
        tick();
        check("imm_regwrite", 32'(RegWriteW), 32'd1);
        check("imm_rd",       32'(RdW),       32'd5);
        check("imm_result",   ResultW,        32'h1234);
        pipeWr(5'd1, 2'd0, 32'hA1, 1'b1);
        tick();
        pipeWr(5'd2, 2'd1, 32'hB2, 1'b1);
        tick();
        pipeWr(5'd3, 2'd2, 32'hC3, 1'b1);
        tick();
        idle();
        tick();
        check("idle_regwrite", 32'(RegWriteW), 32'd0);
        check("idle_rd",       32'(RdW),       32'd0);
        check("idle_hold",     ResultW,        32'hC3);

        // Non-writing pipe results and an x0 completion.
        for (int v = 0; v < 3; v++) begin
            pipeWr((v == 0) ? 5'd0 : 5'd9, 2'd0, 32'h77, 1'b0);
            if (v == 1) ValidM = 1'b0;
            if (v == 2) RegWriteM = 1'b0;
            if (v == 0) luDrive(0, 5'd0, 32'h55);
            tick();
            idle();
            check("nowrite_regwrite", 32'(RegWriteW), 32'd0);
            check("nowrite_busy",     32'(lu_busy),   32'd0);
        end
        check("x0_ready", 32'(lu_ready), 32'h3);

        // A pushed entry is not granted in its push cycle.
        luDrive(0, 5'd6, 32'h66);
        tick();
        idle();
        check("no_bypass", 32'(RegWriteW), 32'd0);
        check("held_busy", 32'(lu_busy),   32'd1);
        expLu(5'd6, 32'h66);
        tick();
        check("lu_rd6", 32'(RdW), 32'd6);
        check("drained_busy", 32'(lu_busy), 32'd0);

        // Starvation: pipe busy every cycle while channel 0 holds an entry.
        pipeWr(5'd10, 2'd0, 32'h100, 1'b1);
        luDrive(0, 5'd7, 32'hAA);
        tick();
        lu_valid = '0;
        check("starve_busy", 32'(lu_busy), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            check("stall_early", 32'(StallReq), 32'd0);
            pipeWr(5'(10 + k), 2'd0, 32'h100 + 32'(k), 1'b1);
            tick();
        end
        check("stall_set", 32'(StallReq), 32'd1);
        pipeWr(5'd19, 2'd0, 32'h109, 1'b1);
        tick();
        check("stall_sat", 32'(StallReq), 32'd1);
        idle();
        expLu(5'd7, 32'hAA);
        tick();
        check("bubble_rd",     32'(RdW),      32'd7);
        check("bubble_data",   ResultW,       32'hAA);
        check("stall_cleared", 32'(StallReq), 32'd0);
        check("bubble_busy",   32'(lu_busy),  32'd0);

        // Channel 1 offered three entries against a depth-2 FIFO.
        pipeWr(5'd20, 2'd0, 32'h200, 1'b1);
        luDrive(1, 5'd11, 32'hB0);
        tick();
        check("ready_one", 32'(lu_ready), 32'h3);
        pipeWr(5'd21, 2'd0, 32'h201, 1'b1);
        luDrive(1, 5'd12, 32'hB1);
        tick();
        check("ready_full", 32'(lu_ready), 32'h1);
        pipeWr(5'd22, 2'd0, 32'h202, 1'b1);
        luDrive(1, 5'd13, 32'hB2);
        tick();
        check("ready_held", 32'(lu_ready), 32'h1);
        ValidM    = 1'b0;
        RegWriteM = 1'b0;
        expLu(5'd11, 32'hB0);
        tick();
        check("ready_after_pop", 32'(lu_ready), 32'h3);
        expLu(5'd12, 32'hB1);
        tick();
        check("pushpop_ready", 32'(lu_ready), 32'h3);
        check("pushpop_busy",  32'(lu_busy),  32'd1);
        lu_valid = '0;
        expLu(5'd13, 32'hB2);
        tick();
        check("ovf_drained", 32'(lu_busy),  32'd0);
        check("ovf_stall",   32'(StallReq), 32'd0);

        // Reset while both FIFOs hold entries and StallReq is high.
        pipeWr(5'd23, 2'd0, 32'h300, 1'b1);
        luDrive(0, 5'd14, 32'hC0);
        luDrive(1, 5'd15, 32'hD0);
        tick();
        lu_valid = '0;
        for (int k = 1; k <= 8; k++) begin
            pipeWr(5'(23 + k), 2'd0, 32'h300 + 32'(k), 1'b1);
            tick();
        end
        check("pre_reset_stall", 32'(StallReq), 32'd1);
        check("pre_reset_busy",  32'(lu_busy),  32'd1);
        idle();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkReset("async_reset");
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post_reset_regwrite", 32'(RegWriteW), 32'd0);
        check("post_reset_busy",     32'(lu_busy),   32'd0);
        check("post_reset_ready",    32'(lu_ready),  32'h3);

        // Round-robin between two channels holding two entries each.
        pipeWr(5'd16, 2'd0, 32'h400, 1'b1);
        luDrive(0, 5'd1, 32'hE0);
        luDrive(1, 5'd2, 32'hF0);
        tick();
        pipeWr(5'd17, 2'd0, 32'h401, 1'b1);
        luDrive(0, 5'd3, 32'hE1);
        luDrive(1, 5'd4, 32'hF1);
        tick();
        check("both_full", 32'(lu_ready), 32'h0);
        idle();
        expLu(5'd1, 32'hE0);
        expLu(5'd2, 32'hF0);
        expLu(5'd3, 32'hE1);
        expLu(5'd4, 32'hF1);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("rr_ready", 32'(lu_ready), 32'(readyExp[j]));
        end
        tick();
        check("rr_busy", 32'(lu_busy), 32'd0);

        repeat (3) tick();
        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
